gray_ptr_gen: RTL and testbench

Per-domain pointer generator for the async FIFO. It keeps the local binary pointer and produces the registered Gray-coded copy that crosses to the other clock domain. It synchronises the remote Gray pointer and decodes it back to binary. It produces the registered full flag (write side) or empty flag (read side) and a local fill level. One instance sits in the write domain and one in the read domain, the two cross-connected through their Gray pointers.

---
 rtl/gray_ptr_gen.sv | 86 ++++++++
 tb/tb_gray_ptr_gen.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/gray_ptr_gen.sv
// Per-domain async FIFO pointer generator: local binary/Gray pointer, remote pointer
// synchroniser, registered full (MODE=0) or empty (MODE=1) flag and fill level.
module gray_ptr_gen #(
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int MODE        = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  inc_i,
    input  logic [ADDR_WIDTH:0]   remote_gray_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [ADDR_WIDTH:0]   ptr_gray_o,
    output logic                  flag_o,
    output logic [ADDR_WIDTH:0]   level_o
);

    localparam int PTR_W = ADDR_WIDTH + 1;
    // Two MSBs set: a full FIFO sees the remote pointer with both top Gray bits inverted.
    localparam logic [PTR_W-1:0] FULL_MASK = (PTR_W)'(3) << (PTR_W - 2);
    localparam logic FLAG_RST = (MODE != 0);

    logic [PTR_W-1:0] bin_q;
    logic [PTR_W-1:0] bin_next;
    logic [PTR_W-1:0] gray_next;
    logic [PTR_W-1:0] sync_q [SYNC_STAGES];
    logic [PTR_W-1:0] sync_gray;
    logic [PTR_W-1:0] remote_bin;
    logic [PTR_W-1:0] level_next;
    logic             flag_next;
    logic             accept;

    assign accept    = inc_i & ~flag_o;
    assign bin_next  = bin_q + {{(PTR_W-1){1'b0}}, accept};
    assign gray_next = bin_next ^ (bin_next >> 1);
    assign sync_gray = sync_q[SYNC_STAGES-1];
    assign addr_o    = bin_q[ADDR_WIDTH-1:0];

    always_comb begin
        remote_bin = '0;
        for (int i = 0; i < PTR_W; i++) begin
            remote_bin[i] = ^(sync_gray >> i);
        end
    end

    always_comb begin
        flag_next  = 1'b0;
        level_next = '0;
        if (MODE != 0) begin
            flag_next  = (gray_next == sync_gray);
            level_next = remote_bin - bin_next;
        end else begin
            flag_next  = (gray_next == (sync_gray ^ FULL_MASK));
            level_next = bin_next - remote_bin;
        end
    end

    // Raw remote_gray_i lands directly in the first stage; nothing combinational in front.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= remote_gray_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bin_q      <= '0;
            ptr_gray_o <= '0;
            flag_o     <= FLAG_RST;
            level_o    <= '0;
        end else begin
            bin_q      <= bin_next;
            ptr_gray_o <= gray_next;
            flag_o     <= flag_next;
            level_o    <= level_next;
        end
    end

endmodule

// File: tb/tb_gray_ptr_gen.sv
// Directed bench for gray_ptr_gen: one write-side and one read-side instance
// sharing clock and reset, driven with hand-computed vectors.
module tb_gray_ptr_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       inc_wr, inc_rd;
    logic [4:0] rem_wr, rem_rd;
    logic [3:0] addr_wr, addr_rd;
    logic [4:0] gray_wr, gray_rd;
    logic       flag_wr, flag_rd;
    logic [4:0] level_wr, level_rd;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    gray_ptr_gen #(.ADDR_WIDTH(4), .SYNC_STAGES(2), .MODE(0)) dut_wr (
        .clk_i(clk), .rst_i(rst), .inc_i(inc_wr), .remote_gray_i(rem_wr),
        .addr_o(addr_wr), .ptr_gray_o(gray_wr), .flag_o(flag_wr), .level_o(level_wr)
    );

    gray_ptr_gen #(.ADDR_WIDTH(4), .SYNC_STAGES(2), .MODE(1)) dut_rd (
        .clk_i(clk), .rst_i(rst), .inc_i(inc_rd), .remote_gray_i(rem_rd),
        .addr_o(addr_rd), .ptr_gray_o(gray_rd), .flag_o(flag_rd), .level_o(level_rd)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] gray5(input int v);
        logic [4:0] b;
        b = v[4:0];
        return b ^ (b >> 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_wr_addr"},  addr_wr,  0);
        check_val({tag, "_wr_gray"},  gray_wr,  0);
        check_val({tag, "_wr_level"}, level_wr, 0);
        check_val({tag, "_wr_flag"},  flag_wr,  0);
        check_val({tag, "_rd_addr"},  addr_rd,  0);
        check_val({tag, "_rd_gray"},  gray_rd,  0);
        check_val({tag, "_rd_level"}, level_rd, 0);
        check_val({tag, "_rd_flag"},  flag_rd,  1);
    endtask

    // after edges 1..7 following a remote change
    int t3_flag [7] = '{1, 1, 0, 0, 0, 0, 1};
    int t4_flag [7] = '{1, 1, 0, 0, 0, 1, 1};
    int t4_level[7] = '{0, 0, 3, 2, 1, 0, 0};

    initial begin
        logic [4:0] prev;
        int         exp_bin;

        rst = 1'b1; inc_wr = 1'b0; inc_rd = 1'b0; rem_wr = '0; rem_rd = '0;
        repeat (2) @(posedge clk);
        #6 rst = 1'b0;

        // 1: asynchronous reset mid-stream
        inc_wr = 1'b1; inc_rd = 1'b1;
        repeat (3) tick();
        check_val("t1_pre_addr", addr_wr, 3);
        #3 rst = 1'b1;
        #1 check_reset_state("t1_async");
        repeat (2) tick();
        check_reset_state("t1_hold");
        inc_wr = 1'b0; inc_rd = 1'b0;
        rst = 1'b0;

        // 2: write-side fill
        for (int i = 0; i < 20; i++) begin
            inc_wr = 1'b1;
            check_val("t2_addr", addr_wr, (i < 16) ? i : 0);
            tick();
            check_val("t2_level", level_wr, (i + 1 < 16) ? i + 1 : 16);
            check_val("t2_flag", flag_wr, (i + 1 >= 16) ? 1 : 0);
        end
        check_val("t2_gray_full", gray_wr, 5'b11000);

        // 3: remote read pointer moves to 4
        rem_wr = 5'b00110;
        for (int c = 0; c < 7; c++) begin
            tick();
            check_val("t3_flag", flag_wr, t3_flag[c]);
            if (c == 2) check_val("t3_level_drop", level_wr, 12);
        end
        check_val("t3_level_full", level_wr, 16);
        check_val("t3_addr", addr_wr, 4);
        check_val("t3_gray", gray_wr, 5'b11110);
        inc_wr = 1'b0;

        // 4: read-side empty hold then three reads
        inc_rd = 1'b1;
        repeat (3) tick();
        check_val("t4_empty_flag", flag_rd, 1);
        check_val("t4_empty_gray", gray_rd, 0);
        check_val("t4_empty_addr", addr_rd, 0);
        rem_rd = 5'b00010;
        for (int c = 0; c < 7; c++) begin
            tick();
            check_val("t4_flag", flag_rd, t4_flag[c]);
            check_val("t4_level", level_rd, t4_level[c]);
        end
        check_val("t4_addr", addr_rd, 3);

        // 5: remote advancing every cycle, pointer wraps twice
        prev = gray_rd;
        for (int e = 1; e <= 70; e++) begin
            rem_rd = gray5(3 + e);
            tick();
            exp_bin = (e <= 3) ? 3 : (e % 32);
            check_val("t5_gray", gray_rd, gray5(exp_bin));
            check_val("t5_addr", addr_rd, exp_bin % 16);
            check_val("t5_onebit", $countones(prev ^ gray_rd), (e >= 4) ? 1 : 0);
            check_val("t5_flag", flag_rd, (e <= 2) ? 1 : 0);
            check_val("t5_level", level_rd, (e <= 2) ? 0 : 1);
            if (e >= 4 && exp_bin == 0) check_val("t5_wrap_prev", prev, 5'b10000);
            prev = gray_rd;
        end
        inc_rd = 1'b0;

        // 6: reset at level 9 with inc held high
        @(posedge clk);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        rem_wr = '0; rem_rd = '0;
        inc_wr = 1'b1;
        repeat (9) tick();
        check_val("t6_level9", level_wr, 9);
        #3 rst = 1'b1;
        #1 check_val("t6_addr", addr_wr, 0);
        check_val("t6_gray", gray_wr, 0);
        check_val("t6_level", level_wr, 0);
        check_val("t6_flag", flag_wr, 0);
        #2 rst = 1'b0;
        tick();
        check_val("t6_first_addr", addr_wr, 1);
        check_val("t6_first_gray", gray_wr, 5'b00001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
